misaligned_access_unit: RTL and testbench

Sequential load/store unit between the execute stage and data memory. It generalises byte-lane handling to a parametrised data width and adds a request/response handshake, and it transparently splits any access that crosses a memory-word boundary into two aligned memory beats. It produces per-beat byte write masks and lane-shifted store data, and merges and sign- or zero-extends load data. Illegal or, optionally, misaligned requests are reported as faults without touching memory.

---
 rtl/misaligned_access_unit.sv | 216 +++++++++++++++++++++
 tb/tb_misaligned_access_unit.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/misaligned_access_unit.sv
`default_nettype none
// ============================================================================
// misaligned_access_unit
//   Load/store unit that splits boundary-crossing accesses into two beats.
//   Revision: 1.0
// ============================================================================
module misaligned_access_unit #(
  parameter int XLEN             = 32,
  parameter int ADDR_WIDTH       = 32,
  parameter bit MISALIGNED_SPLIT = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_read,
  input  logic                  req_write,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_address,
  input  logic [XLEN-1:0]       req_store_data,
  output logic                  resp_valid,
  output logic [XLEN-1:0]       resp_load_data,
  output logic                  resp_fault,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_write,
  output logic [XLEN/8-1:0]     mem_write_mask,
  output logic [XLEN-1:0]       mem_write_data,
  input  logic                  mem_ack,
  input  logic [XLEN-1:0]       mem_read_data
);
  localparam int B = XLEN / 8;
  localparam int O = $clog2(B);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BEAT0 = 2'd1;
  localparam logic [1:0] S_BEAT1 = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]            state, next_state;
  logic [ADDR_WIDTH-1:0] lat_address;
  logic [2:0]            lat_funct3;
  logic                  lat_write, lat_split;
  logic [XLEN-1:0]       lat_store_data, beat0_data;

  logic                  idle, ack;
  logic [ADDR_WIDTH-1:0] src_address;
  logic [2:0]            src_funct3;
  logic [XLEN-1:0]       src_store_data;
  logic [O-1:0]          off;
  logic [3:0]            nbytes;
  logic [4:0]            span;
  logic                  crosses;
  logic [B-1:0]          size_mask;
  logic [XLEN-1:0]       lane_bits;
  logic [2*B-1:0]        wide_mask;
  logic [2*XLEN-1:0]     wide_wdata;
  logic                  funct3_ok, aligned, req_fault;
  logic [XLEN-1:0]       beat0_src, beat1_src, raw, load_value;
  logic [2*XLEN-1:0]     merge_wide;
  logic                  sign_bit;

  logic                  mem_req_nxt, mem_write_nxt, resp_valid_nxt, resp_fault_nxt;
  logic [ADDR_WIDTH-1:0] mem_address_nxt;
  logic [B-1:0]          mem_write_mask_nxt;
  logic [XLEN-1:0]       mem_write_data_nxt, resp_load_data_nxt;

  assign idle      = (state == S_IDLE);
  assign req_ready = idle;
  assign ack       = mem_ack && mem_req;

  // In IDLE the geometry is decoded from the live request so beat0 can be issued at acceptance
  assign src_address    = idle ? req_address    : lat_address;
  assign src_funct3     = idle ? req_funct3     : lat_funct3;
  assign src_store_data = idle ? req_store_data : lat_store_data;

  assign off        = src_address[O-1:0];
  assign nbytes     = 4'd1 << src_funct3[1:0];
  assign span       = 5'(off) + 5'(nbytes);
  assign crosses    = span > 5'(B);
  assign size_mask  = B'((9'd1 << nbytes) - 9'd1);
  assign wide_mask  = {{B{1'b0}}, size_mask} << off;
  assign wide_wdata = {{XLEN{1'b0}}, src_store_data & lane_bits} << {off, 3'b000};

  always_comb begin
    lane_bits = '0;
    for (int i = 0; i < B; i++) lane_bits[8*i +: 8] = {8{size_mask[i]}};
  end

  always_comb begin
    funct3_ok = 1'b0;
    if (req_read) begin
      case (req_funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: funct3_ok = 1'b1;
        3'b011, 3'b110:                         funct3_ok = (XLEN == 64);
        default:                                funct3_ok = 1'b0;
      endcase
    end else begin
      case (req_funct3)
        3'b000, 3'b001, 3'b010: funct3_ok = 1'b1;
        3'b011:                 funct3_ok = (XLEN == 64);
        default:                funct3_ok = 1'b0;
      endcase
    end
  end

  assign aligned   = (off & O'(nbytes - 4'd1)) == '0;
  assign req_fault = (req_read == req_write) || !funct3_ok || (!MISALIGNED_SPLIT && !aligned);

  // The xor isolates the top bit of the kept field, i.e. the sign bit of the access
  assign beat0_src  = (state == S_BEAT1) ? beat0_data : mem_read_data;
  assign beat1_src  = (state == S_BEAT1) ? mem_read_data : '0;
  assign merge_wide = {beat1_src, beat0_src} >> {off, 3'b000};
  assign raw        = merge_wide[XLEN-1:0];
  assign sign_bit   = |(raw & (lane_bits ^ (lane_bits >> 1)));
  assign load_value = (raw & lane_bits) |
                      ((!src_funct3[2] && sign_bit) ? ~lane_bits : '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= S_IDLE;
      lat_address    <= '0;
      lat_funct3     <= '0;
      lat_write      <= 1'b0;
      lat_split      <= 1'b0;
      lat_store_data <= '0;
      beat0_data     <= '0;
      mem_req        <= 1'b0;
      mem_address    <= '0;
      mem_write      <= 1'b0;
      mem_write_mask <= '0;
      mem_write_data <= '0;
      resp_valid     <= 1'b0;
      resp_fault     <= 1'b0;
      resp_load_data <= '0;
    end else begin
      state          <= next_state;
      mem_req        <= mem_req_nxt;
      mem_address    <= mem_address_nxt;
      mem_write      <= mem_write_nxt;
      mem_write_mask <= mem_write_mask_nxt;
      mem_write_data <= mem_write_data_nxt;
      resp_valid     <= resp_valid_nxt;
      resp_fault     <= resp_fault_nxt;
      resp_load_data <= resp_load_data_nxt;
      if (idle && req_valid) begin
        lat_address    <= req_address;
        lat_funct3     <= req_funct3;
        lat_write      <= req_write;
        lat_split      <= crosses;
        lat_store_data <= req_store_data;
      end
      if (state == S_BEAT0 && ack) beat0_data <= mem_read_data;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (req_valid) next_state = req_fault ? S_RESP : S_BEAT0;
      S_BEAT0: if (ack) next_state = lat_split ? S_BEAT1 : S_RESP;
      S_BEAT1: if (ack) next_state = S_RESP;
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    mem_req_nxt        = mem_req;
    mem_address_nxt    = mem_address;
    mem_write_nxt      = mem_write;
    mem_write_mask_nxt = mem_write_mask;
    mem_write_data_nxt = mem_write_data;
    resp_valid_nxt     = 1'b0;
    resp_fault_nxt     = 1'b0;
    resp_load_data_nxt = '0;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          if (req_fault) begin
            resp_valid_nxt = 1'b1;
            resp_fault_nxt = 1'b1;
          end else begin
            mem_req_nxt        = 1'b1;
            mem_address_nxt    = req_address & ~ADDR_WIDTH'(B - 1);
            mem_write_nxt      = req_write;
            mem_write_mask_nxt = wide_mask[B-1:0];
            mem_write_data_nxt = wide_wdata[XLEN-1:0];
          end
        end
      end
      S_BEAT0: begin
        if (ack) begin
          if (lat_split) begin
            mem_address_nxt    = mem_address + ADDR_WIDTH'(B);
            mem_write_mask_nxt = wide_mask[2*B-1:B];
            mem_write_data_nxt = wide_wdata[2*XLEN-1:XLEN];
          end else begin
            mem_req_nxt        = 1'b0;
            resp_valid_nxt     = 1'b1;
            resp_load_data_nxt = lat_write ? '0 : load_value;
          end
        end
      end
      S_BEAT1: begin
        if (ack) begin
          mem_req_nxt        = 1'b0;
          resp_valid_nxt     = 1'b1;
          resp_load_data_nxt = lat_write ? '0 : load_value;
        end
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_misaligned_access_unit.sv
`default_nettype none
// ============================================================================
// tb_misaligned_access_unit
//   Directed and random checks of three unit configurations against a byte-level model.
//   Revision: 1.0
// ============================================================================
module tb_misaligned_access_unit;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic        req_valid = 1'b0, req_read = 1'b0, req_write = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_address = '0;
  logic [63:0] req_store_data = '0;
  logic        mem_ack = 1'b0;
  logic [63:0] mem_read_data = '0;
  int          sel = 0;
  int          n_assert = 0, n_fail = 0;

  logic        a_ready, a_rv, a_rf, a_mreq, a_mw;
  logic [31:0] a_ld, a_ma, a_wd;
  logic [3:0]  a_mk;
  logic        b_ready, b_rv, b_rf, b_mreq, b_mw;
  logic [63:0] b_ld, b_wd;
  logic [31:0] b_ma;
  logic [7:0]  b_mk;
  logic        c_ready, c_rv, c_rf, c_mreq, c_mw;
  logic [31:0] c_ld, c_ma, c_wd;
  logic [3:0]  c_mk;

  misaligned_access_unit #(.XLEN(32), .ADDR_WIDTH(32), .MISALIGNED_SPLIT(1'b1)) dut_a (
    .clk(clk), .reset(reset), .req_valid(req_valid && sel == 0), .req_ready(a_ready),
    .req_read(req_read), .req_write(req_write), .req_funct3(req_funct3),
    .req_address(req_address), .req_store_data(req_store_data[31:0]),
    .resp_valid(a_rv), .resp_load_data(a_ld), .resp_fault(a_rf),
    .mem_req(a_mreq), .mem_address(a_ma), .mem_write(a_mw), .mem_write_mask(a_mk),
    .mem_write_data(a_wd), .mem_ack(mem_ack && sel == 0), .mem_read_data(mem_read_data[31:0]));

  misaligned_access_unit #(.XLEN(64), .ADDR_WIDTH(32), .MISALIGNED_SPLIT(1'b1)) dut_b (
    .clk(clk), .reset(reset), .req_valid(req_valid && sel == 1), .req_ready(b_ready),
    .req_read(req_read), .req_write(req_write), .req_funct3(req_funct3),
    .req_address(req_address), .req_store_data(req_store_data),
    .resp_valid(b_rv), .resp_load_data(b_ld), .resp_fault(b_rf),
    .mem_req(b_mreq), .mem_address(b_ma), .mem_write(b_mw), .mem_write_mask(b_mk),
    .mem_write_data(b_wd), .mem_ack(mem_ack && sel == 1), .mem_read_data(mem_read_data));

  misaligned_access_unit #(.XLEN(32), .ADDR_WIDTH(32), .MISALIGNED_SPLIT(1'b0)) dut_c (
    .clk(clk), .reset(reset), .req_valid(req_valid && sel == 2), .req_ready(c_ready),
    .req_read(req_read), .req_write(req_write), .req_funct3(req_funct3),
    .req_address(req_address), .req_store_data(req_store_data[31:0]),
    .resp_valid(c_rv), .resp_load_data(c_ld), .resp_fault(c_rf),
    .mem_req(c_mreq), .mem_address(c_ma), .mem_write(c_mw), .mem_write_mask(c_mk),
    .mem_write_data(c_wd), .mem_ack(mem_ack && sel == 2), .mem_read_data(mem_read_data[31:0]));

  logic        v_ready, v_rv, v_rf, v_mreq, v_mw;
  logic [63:0] v_ld, v_wd;
  logic [31:0] v_ma;
  logic [7:0]  v_mk;

  always_comb begin
    case (sel)
      1: begin
        v_ready = b_ready; v_rv = b_rv; v_rf = b_rf; v_mreq = b_mreq; v_mw = b_mw;
        v_ld = b_ld; v_wd = b_wd; v_ma = b_ma; v_mk = b_mk;
      end
      2: begin
        v_ready = c_ready; v_rv = c_rv; v_rf = c_rf; v_mreq = c_mreq; v_mw = c_mw;
        v_ld = {32'h0, c_ld}; v_wd = {32'h0, c_wd}; v_ma = c_ma; v_mk = {4'h0, c_mk};
      end
      default: begin
        v_ready = a_ready; v_rv = a_rv; v_rf = a_rf; v_mreq = a_mreq; v_mw = a_mw;
        v_ld = {32'h0, a_ld}; v_wd = {32'h0, a_wd}; v_ma = a_ma; v_mk = {4'h0, a_mk};
      end
    endcase
  end

  // Byte-addressed memory; untouched bytes read back as an address hash
  logic [7:0] mem [bit [31:0]];

  function automatic logic [7:0] rd_byte(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h3C;
  endfunction

  function automatic logic [63:0] mem_word(input logic [31:0] w, input int bb);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < bb; i++) v[8*i +: 8] = rd_byte(w + 32'(i));
    return v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic run_txn(input int s, input bit rd, input bit wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [63:0] sd, input int dly,
                         output logic [63:0] obs_ld, output int obs_lat);
    int bb, n, off, exp_nb, nb, wc, lane, exp_lat;
    bit x64, f3ok, exp_fault, got;
    logic [31:0] a, w;
    logic [31:0] ea[2], ra[2];
    logic [7:0]  em[2], rm[2];
    logic [63:0] ed[2], rwd[2];
    logic        rw[2];
    logic [63:0] exp_ld;
    logic        obs_rf;

    bb = (s == 1) ? 8 : 4;
    x64 = (s == 1);
    n = 1 << f3[1:0];
    off = int'(addr & 32'(bb - 1));
    if (rd) f3ok = (f3 != 3'd7) && (x64 || (f3 != 3'd3 && f3 != 3'd6));
    else    f3ok = (f3 <= 3'd2) || (f3 == 3'd3 && x64);
    exp_fault = (rd == wr) || !f3ok || (s == 2 && (off % n) != 0);

    exp_nb = 0;
    for (int i = 0; i < 2; i++) begin ea[i] = '0; em[i] = '0; ed[i] = '0; end
    exp_ld = '0;
    if (!exp_fault) begin
      for (int j = 0; j < n; j++) begin
        a = addr + 32'(j);
        w = a & ~32'(bb - 1);
        lane = int'(a & 32'(bb - 1));
        if (exp_nb == 0 || w != ea[exp_nb-1]) begin
          exp_nb++;
          ea[exp_nb-1] = w;
        end
        em[exp_nb-1][lane] = 1'b1;
        ed[exp_nb-1][8*lane +: 8] = sd[8*j +: 8];
      end
      if (rd) begin
        for (int j = 0; j < n; j++) exp_ld[8*j +: 8] = rd_byte(addr + 32'(j));
        if (!f3[2] && n < bb && exp_ld[8*n-1])
          for (int j = n; j < bb; j++) exp_ld[8*j +: 8] = 8'hFF;
      end
    end
    exp_lat = exp_fault ? 1 : exp_nb * (dly + 1) + 1;

    sel = s;
    @(negedge clk);
    req_read = rd; req_write = wr; req_funct3 = f3; req_address = addr;
    req_store_data = sd; req_valid = 1'b1; mem_ack = 1'b0;
    chk("ready_before_accept", v_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    got = 0; nb = 0; wc = 0; obs_lat = 0; obs_ld = '0; obs_rf = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      mem_ack = 1'b0;
      mem_read_data = {$urandom, $urandom};
      if (v_mreq) begin
        if (nb < 2) begin
          if (wc == 0) begin
            ra[nb] = v_ma; rm[nb] = v_mk; rwd[nb] = v_wd; rw[nb] = v_mw;
          end else begin
            chk("hold_addr", v_ma, ra[nb]);
            chk("hold_mask", v_mk, rm[nb]);
            chk("hold_data", v_wd, rwd[nb]);
            chk("hold_write", v_mw, rw[nb]);
          end
        end
        if (wc == dly) begin
          mem_ack = 1'b1;
          mem_read_data = mem_word(v_ma, bb);
          nb++;
          wc = 0;
        end else wc++;
      end else begin
        mem_ack = 1'($urandom_range(0, 1));
      end
      if (v_rv) begin
        got = 1; obs_lat = k; obs_ld = v_ld; obs_rf = v_rf;
      end
      @(posedge clk); #1;
      if (got) break;
    end
    mem_ack = 1'b0;

    chk("resp_seen", 64'(got), 64'(1));
    if (got) begin
      chk("latency", 64'(obs_lat), 64'(exp_lat));
      chk("fault", 64'(obs_rf), 64'(exp_fault));
      chk("load_data", obs_ld, exp_ld);
      chk("resp_pulse", v_rv, 0);
    end
    chk("beat_count", 64'(nb), 64'(exp_nb));
    for (int i = 0; i < 2; i++) begin
      if (i < nb && i < exp_nb) begin
        chk("beat_addr", ra[i], ea[i]);
        chk("beat_mask", rm[i], em[i]);
        chk("beat_data", rwd[i], ed[i]);
        chk("beat_write", rw[i], wr);
      end
    end
    if (wr && !exp_fault)
      for (int j = 0; j < n; j++) mem[addr + 32'(j)] = sd[8*j +: 8];
  endtask

  initial begin
    logic [63:0] ld;
    int lat, s, r, dly;
    bit rd, wr;
    logic [2:0] f3;
    logic [31:0] addr;

    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", a_ready, 1);
    chk("rst_resp_valid", a_rv, 0);
    chk("rst_resp_fault", a_rf, 0);
    chk("rst_load_data", a_ld, 0);
    chk("rst_mem_req", a_mreq, 0);
    chk("rst_mem_write", a_mw, 0);
    chk("rst_mem_addr", a_ma, 0);
    chk("rst_mem_mask", a_mk, 0);
    chk("rst_mem_data", a_wd, 0);
    @(negedge clk); reset = 1'b0;

    mem[32'h1000] = 8'hDD; mem[32'h1001] = 8'hCC; mem[32'h1002] = 8'hBB; mem[32'h1003] = 8'hAA;
    mem[32'h1004] = 8'hF4; mem[32'h1005] = 8'h33; mem[32'h1006] = 8'h22; mem[32'h1007] = 8'h11;

    run_txn(0, 1, 0, 3'b001, 32'h1003, 64'h0, 0, ld, lat);
    chk("lh_split_value", ld, 64'hFFFFF4AA);
    run_txn(0, 1, 0, 3'b101, 32'h1003, 64'h0, 0, ld, lat);
    chk("lhu_split_value", ld, 64'h0000F4AA);
    run_txn(0, 0, 1, 3'b010, 32'h2002, 64'h12345678, 0, ld, lat);
    chk("sw_split_latency", 64'(lat), 64'd3);
    run_txn(0, 0, 1, 3'b000, 32'h3001, 64'hA5, 3, ld, lat);
    chk("sb_wait_latency", 64'(lat), 64'd5);
    run_txn(2, 1, 0, 3'b010, 32'h4001, 64'h0, 0, ld, lat);
    chk("nosplit_lw_fault_lat", 64'(lat), 64'd1);
    run_txn(2, 1, 0, 3'b011, 32'h4000, 64'h0, 0, ld, lat);
    run_txn(0, 1, 0, 3'b011, 32'h4000, 64'h0, 0, ld, lat);
    run_txn(1, 1, 0, 3'b011, 32'h0FFFFFFD, 64'h0, 1, ld, lat);
    run_txn(1, 0, 1, 3'b011, 32'hFFFFFFFC, 64'h0123456789ABCDEF, 0, ld, lat);
    run_txn(0, 1, 1, 3'b010, 32'h5000, 64'h0, 0, ld, lat);
    run_txn(0, 0, 0, 3'b010, 32'h5000, 64'h0, 0, ld, lat);

    // Reset while the second beat of a split store is waiting for its ack
    sel = 0;
    @(negedge clk);
    req_read = 1'b0; req_write = 1'b1; req_funct3 = 3'b010;
    req_address = 32'h2002; req_store_data = 64'h12345678; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rst_beat0_req", v_mreq, 1);
    mem_ack = 1'b1;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    chk("rst_beat1_req", v_mreq, 1);
    chk("rst_beat1_addr", v_ma, 32'h2004);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("rst_async_mem_req", v_mreq, 0);
    chk("rst_async_resp", v_rv, 0);
    @(negedge clk); reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk("rst_after_ready", v_ready, 1);
      chk("rst_after_resp", v_rv, 0);
      chk("rst_after_mem_req", v_mreq, 0);
    end

    for (int t = 0; t < 200; t++) begin
      s = $urandom_range(0, 2);
      r = $urandom_range(0, 9);
      rd = (r == 0) ? 1'b1 : (r == 1) ? 1'b0 : r[0];
      wr = (r == 0) ? 1'b1 : (r == 1) ? 1'b0 : !r[0];
      f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) addr = 32'hFFFFFFF0 | 32'($urandom_range(0, 15));
      else addr = 32'h100 + 32'($urandom_range(0, 63));
      dly = $urandom_range(0, 2);
      run_txn(s, rd, wr, f3, addr, {$urandom, $urandom}, dly, ld, lat);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
